// File: rtl/strobe_monitor_pkg.sv
// Shared types and width helper for the strobe monitor.
package strobe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } strobe_mon_state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/strobe_monitor_if.sv
// Strobe input and health-report outputs of the strobe monitor.
interface strobe_monitor_if #(
    parameter int PW = 4
);
    logic          strobe;
    logic          locked;
    logic          fault;
    logic [PW-1:0] period;
    logic          period_valid;

    modport master (
        output strobe,
        input  locked, fault, period, period_valid
    );

    modport slave (
        input  strobe,
        output locked, fault, period, period_valid
    );
endinterface

// File: rtl/strobe_interval_counter.sv
// Cycles-since-last-strobe counter with interval and timeout outputs.
module strobe_interval_counter
    import strobe_pkg::*;
#(
    parameter  int DIV = 10,
    parameter  int TOL = 0,
    localparam int PW  = bits_for(DIV + TOL + 2)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          strobe,
    input  logic          active,
    output logic [PW-1:0] interval,
    output logic          strobe_seen,
    output logic          timeout
);
    localparam int CW = bits_for(DIV + TOL + 1);
    localparam logic [CW-1:0] MAX = CW'(DIV + TOL);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (strobe || !active) begin
            cnt <= '0;
        end else if (cnt != MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign interval    = PW'(cnt) + PW'(1);
    assign strobe_seen = strobe && active;
    // A strobe on the timeout cycle is treated as late, not as a timeout.
    assign timeout     = active && !strobe && (cnt == MAX);

endmodule

// File: rtl/strobe_monitor.sv
// Periodic strobe lock/fault monitor; STROBE_MONITOR_PERIOD_EN
// enables the o_period/o_period_valid report register.
module strobe_monitor
    import strobe_pkg::*;
#(
    parameter  int DIV        = 10,
    parameter  int TOL        = 0,
    parameter  int LOCK_COUNT = 4,
    localparam int PW         = bits_for(DIV + TOL + 2)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    strobe_monitor_if.slave  bus
);
    localparam int GW = bits_for(LOCK_COUNT + 1);
    localparam logic [PW-1:0] LO = PW'(DIV - TOL);
    localparam logic [PW-1:0] HI = PW'(DIV + TOL);

    if (DIV < 2) begin : g_div_chk
        $error("strobe_monitor: DIV must be >= 2");
    end
    if (TOL < 0 || TOL >= DIV) begin : g_tol_chk
        $error("strobe_monitor: TOL must satisfy 0 <= TOL < DIV");
    end
    if (LOCK_COUNT < 1) begin : g_lock_chk
        $error("strobe_monitor: LOCK_COUNT must be >= 1");
    end

    strobe_mon_state_e state_q, state_d;
    logic [GW-1:0]     good_q, good_d, good_inc;
    logic              locked_q, fault_q, fault_d;
    logic [PW-1:0]     interval;
    logic              strobe_seen, timeout, good;

    strobe_interval_counter #(
        .DIV (DIV),
        .TOL (TOL)
    ) u_cnt (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .strobe      (bus.strobe),
        .active      (state_q != IDLE),
        .interval    (interval),
        .strobe_seen (strobe_seen),
        .timeout     (timeout)
    );

    assign good     = (interval >= LO) && (interval <= HI);
    assign good_inc = good_q + GW'(1);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        fault_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.strobe) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (strobe_seen && good) begin
                    good_d = good_inc;
                    if (good_inc == GW'(LOCK_COUNT)) state_d = LOCKED;
                end else if (strobe_seen) begin
                    good_d = '0;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if ((strobe_seen && !good) || timeout) begin
                    fault_d = 1'b1;
                    good_d  = '0;
                    state_d = strobe_seen ? ACQUIRE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            locked_q <= (state_d == LOCKED);
            fault_q  <= fault_d;
        end
    end

    assign bus.locked = locked_q;
    assign bus.fault  = fault_q;

`ifdef STROBE_MONITOR_PERIOD_EN
    logic [PW-1:0] period_q;
    logic          pvalid_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            pvalid_q <= strobe_seen;
            if (strobe_seen) period_q <= interval;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = pvalid_q;
`else
    assign bus.period       = '0;
    assign bus.period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_strobe_monitor.sv
// Bench for strobe_monitor: directed plan plus random gaps vs. a timestamp model.
module tb_strobe_monitor;
    localparam int DIV = 10;
    localparam int TOL = 1;
    localparam int LC  = 4;
    localparam int PW  = strobe_pkg::bits_for(DIV + TOL + 2);
`ifdef STROBE_MONITOR_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;
    int   fault_seen = 0;

    strobe_monitor_if #(.PW(PW)) bus ();

    strobe_monitor #(
        .DIV        (DIV),
        .TOL        (TOL),
        .LOCK_COUNT (LC)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reference: spec states tracked with timestamps of the last reference strobe.
    int   mode;
    int   run;
    int   cyc = 0;
    int   ref_c;
    int   k;
    logic e_locked, e_fault, e_pv;
    int   e_period;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0; run = 0;
            e_locked = 0; e_fault = 0; e_pv = 0; e_period = 0;
        end else begin
            cyc++;
            e_fault = 0;
            e_pv = 0;
            k = cyc - ref_c;
            if (bus.strobe) begin
                if (mode == 0) begin
                    mode = 1; run = 0;
                end else begin
                    e_pv = 1;
                    e_period = k;
                    if (k >= DIV - TOL && k <= DIV + TOL) begin
                        if (mode == 1) begin
                            run++;
                            if (run == LC) mode = 2;
                        end
                    end else begin
                        if (mode == 2) e_fault = 1;
                        mode = 1; run = 0;
                    end
                end
                ref_c = cyc;
            end else if (mode != 0 && k == DIV + TOL + 1) begin
                if (mode == 2) e_fault = 1;
                mode = 0;
            end
            e_locked = (mode == 2);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("locked", 32'(bus.locked), 32'(e_locked));
        chk("fault", 32'(bus.fault), 32'(e_fault));
        chk("period", 32'(bus.period), PEN ? e_period : 0);
        chk("period_valid", 32'(bus.period_valid), 32'(PEN & e_pv));
        if (bus.fault) fault_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(int gap);
        bus.strobe = 1'b0;
        repeat (gap - 1) step();
        bus.strobe = 1'b1;
        step();
        bus.strobe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int f0;
    int gaps[3] = '{9, 11, 10};

    initial begin
        rst_n = 1'b0;
        bus.strobe = 1'b0;
        repeat (3) step();
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_period", 32'(bus.period), 0);
        chk("rst_pv", 32'(bus.period_valid), 0);
        rst_n = 1'b1;
        repeat (2) step();

        pulse(3);
        chk("first_pv", 32'(bus.period_valid), 0);
        for (int i = 0; i < 4; i++) begin
            pulse(10);
            chk("acq_period", 32'(bus.period), PEN ? 10 : 0);
            chk("acq_pv", 32'(bus.period_valid), 32'(PEN));
            chk("acq_locked", 32'(bus.locked), (i == 3) ? 1 : 0);
        end

        pulse(8);
        chk("early_fault", 32'(bus.fault), 1);
        chk("early_locked", 32'(bus.locked), 0);
        chk("early_period", 32'(bus.period), PEN ? 8 : 0);
        step();
        chk("early_fault_1cyc", 32'(bus.fault), 0);
        repeat (4) pulse(10);
        chk("relock", 32'(bus.locked), 1);

        foreach (gaps[i]) begin
            pulse(gaps[i]);
            chk("tol_locked", 32'(bus.locked), 1);
            chk("tol_fault", 32'(bus.fault), 0);
            chk("tol_period", 32'(bus.period), PEN ? gaps[i] : 0);
        end

        repeat (11) step();
        chk("pre_timeout_locked", 32'(bus.locked), 1);
        step();
        chk("timeout_fault", 32'(bus.fault), 1);
        chk("timeout_locked", 32'(bus.locked), 0);
        step();
        chk("timeout_fault_1cyc", 32'(bus.fault), 0);
        pulse(5);
        chk("idle_pv", 32'(bus.period_valid), 0);

        pulse(10);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("async_locked", 32'(bus.locked), 0);
        chk("async_fault", 32'(bus.fault), 0);
        chk("async_period", 32'(bus.period), 0);
        chk("async_pv", 32'(bus.period_valid), 0);
        step();
        rst_n = 1'b1;
        pulse(4);
        chk("post_rst_pv", 32'(bus.period_valid), 0);
        for (int i = 0; i < 4; i++) begin
            pulse(10);
            chk("post_rst_locked", 32'(bus.locked), (i == 3) ? 1 : 0);
        end

        f0 = fault_seen;
        bus.strobe = 1'b1;
        repeat (20) step();
        bus.strobe = 1'b0;
        chk("hold_locked", 32'(bus.locked), 0);
        chk("hold_period", 32'(bus.period), PEN ? 1 : 0);
        step();
        chk("hold_fault_count", 32'(fault_seen - f0), 1);

        repeat (300) begin
            if ($urandom_range(49) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            if ($urandom_range(3) != 0) pulse($urandom_range(11, 9));
            else pulse($urandom_range(15, 1));
        end
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
